// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the instruction-fetch state encoding.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; a bubble keeps the PC and writes an invalid NOP.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (load_i) begin
      if (bubble_i) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_i;
        instr_d = instr_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, hold buffer for stalled responses, IF/ID register.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            ifid_load, ifid_bubble;
  logic [XLEN-1:0] ifid_instr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    drain_addr_d = drain_addr_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_instr   = hold_q;
    imem_req     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (pc_write && if_write) begin
            ifid_load  = 1'b1;
            ifid_instr = imem_rdata;
            pc_d       = pc_q + 32'd4;
          end else begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end else if (if_write) begin
          ifid_load   = 1'b1;
          ifid_bubble = 1'b1;
        end
      end
      StHold: begin
        if (pc_write && if_write) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
          state_d   = StFetch;
        end
      end
      StDrain: begin
        // Old request stays on the bus until it completes; its data is dropped.
        imem_req = 1'b1;
        if (imem_ready) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase

    if (branch_taken) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
      if (state_q != StDrain) begin
        ifid_load    = 1'b1;
        ifid_bubble  = 1'b1;
        hold_d       = '0;
        drain_addr_d = pc_q;
        state_d      = (state_q == StFetch && !imem_ready) ? StDrain : StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_q),
    .instr_i  (ifid_instr),
    .pc_o     (if_id_pc),
    .instr_o  (if_id_instr),
    .valid_o  (if_id_valid)
  );

  assign if_id_rs1 = if_id_instr[19:15];
  assign if_id_rs2 = if_id_instr[24:20];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall/hold, branch flush, drain, wrap, async reset.
module tb_if_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, if_write, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1, if_id_rs2;

  int n_vec = 0;
  int n_err = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .if_write      (if_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00A5_8013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst_n = 1'b0; pc_write = 1'b1; if_write = 1'b1; branch_taken = 1'b0;
    branch_target = '0; imem_ready = 1'b1;
    #12;
    @(negedge clk);
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    n_vec++;
    if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", if_id_valid); end
    n_vec++;
    if (if_id_instr !== NOP_W) begin n_err++; $display("FAIL rst_instr: got %h expected %h", if_id_instr, NOP_W); end
    n_vec++;
    if (if_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_ifid_pc: got %h expected 0", if_id_pc); end
    n_vec++;
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    n_vec++;
    w = NOP_W;
    if (if_id_rs1 !== w[19:15] || if_id_rs2 !== w[24:20]) begin
      n_err++; $display("FAIL rst_rs: got %h/%h expected %h/%h", if_id_rs1, if_id_rs2, w[19:15], w[24:20]);
    end
    n_vec++;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] w;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    cycle();
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr0", imem_addr, 32'h0);
    chk("fetch_valid0", {31'b0, if_id_valid}, 32'd0);
    cycle();
    chk("s0_pc", if_id_pc, 32'h0);
    chk("s0_valid", {31'b0, if_id_valid}, 32'd1);
    chk("s0_instr", if_id_instr, mem_word(32'h0));
    chk("s0_addr", imem_addr, 32'h4);
    cycle();
    chk("s1_pc", if_id_pc, 32'h4);
    chk("s1_addr", imem_addr, 32'h8);
  endtask

  task automatic test_load_use_stall();
    logic [31:0] w;
    pc_write = 1'b0; if_write = 1'b0;
    cycle();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_ifid_pc", if_id_pc, 32'h4);
    chk("hold_addr", imem_addr, 32'h8);
    pc_write = 1'b1; if_write = 1'b1;
    cycle();
    chk("held_pc", if_id_pc, 32'h8);
    chk("held_instr", if_id_instr, mem_word(32'h8));
    chk("held_valid", {31'b0, if_id_valid}, 32'd1);
    chk("held_addr", imem_addr, 32'hC);
    w = mem_word(32'h8);
    chk("held_rs1", {27'b0, if_id_rs1}, {27'b0, w[19:15]});
    chk("held_rs2", {27'b0, if_id_rs2}, {27'b0, w[24:20]});
  endtask

  task automatic test_branch_stall();
    pc_write = 1'b0; if_write = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    cycle();
    chk("br_addr", imem_addr, 32'h100);
    chk("br_valid", {31'b0, if_id_valid}, 32'd0);
    chk("br_instr", if_id_instr, NOP_W);
    chk("br_req", {31'b0, imem_req}, 32'd1);
    branch_taken = 1'b0; pc_write = 1'b1; if_write = 1'b1;
    cycle();
    chk("br_tgt_pc", if_id_pc, 32'h100);
    chk("br_tgt_instr", if_id_instr, mem_word(32'h100));
    chk("br_tgt_valid", {31'b0, if_id_valid}, 32'd1);
  endtask

  task automatic test_drain();
    imem_ready = 1'b0;
    cycle();
    chk("wait_bubble_valid", {31'b0, if_id_valid}, 32'd0);
    chk("wait_bubble_instr", if_id_instr, NOP_W);
    chk("wait_addr", imem_addr, 32'h104);
    cycle();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    cycle();
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr_old", imem_addr, 32'h104);
    branch_target = 32'h0000_0302;
    cycle();
    chk("drain_addr_hold", imem_addr, 32'h104);
    branch_target = 32'h0000_0100;
    cycle();
    branch_taken = 1'b0; imem_ready = 1'b1;
    cycle();
    chk("drain_done_addr", imem_addr, 32'h100);
    chk("drain_discard", {31'b0, if_id_valid}, 32'd0);
    cycle();
    chk("drain_next_pc", if_id_pc, 32'h100);
    chk("drain_next_instr", if_id_instr, mem_word(32'h100));
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    cycle();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    cycle();
    chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0);
  endtask

  task automatic test_reset_in_drain();
    cycle();
    chk("pre_addr", imem_addr, 32'h4);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    cycle();
    chk("rd_addr_old", imem_addr, 32'h4);
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rd_req", {31'b0, imem_req}, 32'd0);
    chk("rd_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rd_idle_req", {31'b0, imem_req}, 32'd0);
    cycle();
    chk("rd_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("rd_fetch_valid", {31'b0, if_id_valid}, 32'd0);
    cycle();
    chk("rd_first_pc", if_id_pc, 32'h0);
    chk("rd_first_instr", if_id_instr, mem_word(32'h0));
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use_stall();
    test_branch_stall();
    test_drain();
    test_wrap();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
